// File: rtl/ram_wr_gen_if.sv
// Bundle of the fill control inputs and the RAM port-A write/status outputs.
// The master modport belongs to the generator and the slave modport to its user.
interface ram_wr_gen_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              start;
    logic              abort;
    logic              cont;
    logic [1:0]        mode;
    logic [DATA_W-1:0] seed;
    logic              ram_wr_en;
    logic              ram_wr_we;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              rd_flag;
    logic              busy;
    logic              done;
    logic [7:0]        pass_cnt;

    modport master (
        input  start, abort, cont, mode, seed,
        output ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data,
               rd_flag, busy, done, pass_cnt
    );

    modport slave (
        output start, abort, cont, mode, seed,
        input  ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data,
               rd_flag, busy, done, pass_cnt
    );
endinterface

// File: rtl/ram_wr_gen.sv
// Write-side pattern generator: fills DEPTH RAM words per pass with one of four
// patterns, single-shot or wrapping, and raises a sticky rd_flag at a fill threshold.
//
//   state | meaning
//   IDLE  | no writes issued; waiting for a start pulse
//   WRITE | one RAM write per cycle at ram_wr_addr
module ram_wr_gen #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int RD_THRESH = 32
) (
    input  logic              clk,
    input  logic              rst,
    ram_wr_gen_if.master      bus
);
    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic [DATA_W-1:0] seed_q, seed_nxt;
    logic              cont_q, cont_nxt;
    logic              en_q, en_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              rd_flag_q, rd_flag_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic [7:0]        pass_q, pass_nxt;
    logic              last_word;
    logic              thresh_word;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                  input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] i);
        logic [31:0]       iw;
        logic [DATA_W-1:0] p;
        iw = 32'(i);
        case (m)
            2'd0:    p = iw[DATA_W-1:0];
            2'd1:    p = s + iw[DATA_W-1:0];
            2'd2:    p = DATA_W'(1) << (iw % 32'(DATA_W));
            default: p = s;
        endcase
        return p;
    endfunction

    assign last_word   = (addr_q == ADDR_W'(DEPTH - 1));
    assign thresh_word = (addr_q == ADDR_W'(RD_THRESH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= '0;
            seed_q    <= '0;
            cont_q    <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_flag_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            pass_q    <= '0;
        end else begin
            state     <= state_nxt;
            mode_q    <= mode_nxt;
            seed_q    <= seed_nxt;
            cont_q    <= cont_nxt;
            en_q      <= en_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            rd_flag_q <= rd_flag_nxt;
            addr_q    <= addr_nxt;
            data_q    <= data_nxt;
            pass_q    <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = WRITE;
            WRITE:   if (bus.abort || (last_word && !cont_q)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mode_nxt    = mode_q;
        seed_nxt    = seed_q;
        cont_nxt    = cont_q;
        en_nxt      = en_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        rd_flag_nxt = rd_flag_q;
        addr_nxt    = addr_q;
        data_nxt    = data_q;
        pass_nxt    = pass_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    mode_nxt    = bus.mode;
                    seed_nxt    = bus.seed;
                    cont_nxt    = bus.cont;
                    en_nxt      = 1'b1;
                    busy_nxt    = 1'b1;
                    rd_flag_nxt = 1'b0;
                    addr_nxt    = '0;
                    data_nxt    = pattern(bus.mode, bus.seed, '0);
                    pass_nxt    = '0;
                end
            end
            WRITE: begin
                // The threshold write is issued even if this cycle aborts.
                if (thresh_word) rd_flag_nxt = 1'b1;
                if (bus.abort) begin
                    en_nxt   = 1'b0;
                    busy_nxt = 1'b0;
                end else if (last_word) begin
                    if (pass_q != 8'hFF) pass_nxt = pass_q + 8'd1;
                    if (cont_q) begin
                        addr_nxt = '0;
                        data_nxt = pattern(mode_q, seed_q, '0);
                    end else begin
                        en_nxt   = 1'b0;
                        busy_nxt = 1'b0;
                        done_nxt = 1'b1;
                    end
                end else begin
                    addr_nxt = addr_q + ADDR_W'(1);
                    data_nxt = pattern(mode_q, seed_q, addr_q + ADDR_W'(1));
                end
            end
            default: begin
                en_nxt   = 1'b0;
                busy_nxt = 1'b0;
            end
        endcase
    end

    assign bus.ram_wr_en   = en_q;
    assign bus.ram_wr_we   = en_q;
    assign bus.ram_wr_addr = addr_q;
    assign bus.ram_wr_data = data_q;
    assign bus.rd_flag     = rd_flag_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass_cnt    = pass_q;
endmodule

// File: tb/tb_ram_wr_gen.sv
// Self-checking bench for ram_wr_gen: pattern table plus scoreboard of expected
// writes, with hand sequences for wrap/abort, restart, reset and a 4-word instance.
module tb_ram_wr_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    ram_wr_gen_if #(.DATA_W(8), .ADDR_W(6)) bus ();
    ram_wr_gen_if #(.DATA_W(8), .ADDR_W(2)) bus_s ();

    ram_wr_gen #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .RD_THRESH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    ram_wr_gen #(.DATA_W(8), .ADDR_W(2), .DEPTH(4), .RD_THRESH(4)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.master)
    );

    typedef struct {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] seed;
        logic [7:0] d0;
        logic [7:0] dlast;
    } vec_t;

    wr_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [1:0] m, input logic [7:0] s, input int i);
        case (m)
            2'd0:    return 8'(i);
            2'd1:    return s + 8'(i);
            2'd2:    return 8'h01 << (i % 8);
            default: return s;
        endcase
    endfunction

    task automatic pulse_start(input logic [1:0] m, input logic [7:0] s, input logic c);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.seed  = s;
        bus.cont  = c;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},   32'(bus.ram_wr_en),   32'd0);
        chk({tag, "_we"},   32'(bus.ram_wr_we),   32'd0);
        chk({tag, "_addr"}, 32'(bus.ram_wr_addr), 32'd0);
        chk({tag, "_data"}, 32'(bus.ram_wr_data), 32'd0);
        chk({tag, "_rd"},   32'(bus.rd_flag),     32'd0);
        chk({tag, "_busy"}, 32'(bus.busy),        32'd0);
        chk({tag, "_done"}, 32'(bus.done),        32'd0);
        chk({tag, "_pass"}, 32'(bus.pass_cnt),    32'd0);
    endtask

    // Non-continuous fill checked against the scoreboard; optionally pulses a
    // stray start at write glitch_at or a reset at write rst_at.
    task automatic run_fill(input logic [1:0] m, input logic [7:0] s,
                            input int glitch_at, input int rst_at,
                            output logic [7:0] d0, output logic [7:0] dlast);
        int  k   = 0;
        int  cyc = 0;
        bit  fin = 0;
        bit  did_rst;
        wr_t e;
        d0 = '0;
        dlast = '0;
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back('{a: 6'(i), d: exp_data(m, s, i)});
        pulse_start(m, s, 1'b0);
        while (!fin) begin
            if (cyc >= 100) begin
                chk("fill_timeout", 32'(cyc), 32'd0);
                fin = 1;
            end else if (bus.ram_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("fill_overrun", 32'(k), 32'd63);
                    fin = 1;
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.ram_wr_addr), 32'(e.a));
                    chk("wr_data", 32'(bus.ram_wr_data), 32'(e.d));
                    chk("wr_we",   32'(bus.ram_wr_we),   32'd1);
                    chk("wr_rd_flag", 32'(bus.rd_flag), 32'(k >= 32));
                    chk("wr_done", 32'(bus.done), 32'd0);
                    if (k == 0)  d0 = bus.ram_wr_data;
                    if (k == 63) dlast = bus.ram_wr_data;
                    did_rst = (k == rst_at);
                    if (did_rst) rst = 1'b1;
                    if (k == glitch_at) begin
                        bus.start = 1'b1;
                        bus.mode  = 2'd3;
                        bus.seed  = 8'h55;
                    end
                    k++;
                    @(negedge clk);
                    cyc++;
                    bus.start = 1'b0;
                    if (did_rst) begin
                        chk_all_zero("mid_rst");
                        rst = 1'b0;
                        exp_q.delete();
                        fin = 1;
                    end
                end
            end else begin
                chk("end_count", 32'(k), 32'd64);
                chk("end_done",  32'(bus.done),     32'd1);
                chk("end_busy",  32'(bus.busy),     32'd0);
                chk("end_pass",  32'(bus.pass_cnt), 32'd1);
                chk("end_rd",    32'(bus.rd_flag),  32'd1);
                @(negedge clk);
                chk("done_pulse", 32'(bus.done),      32'd0);
                chk("en_after",   32'(bus.ram_wr_en), 32'd0);
                fin = 1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[4];
        logic [7:0] d0, dl;
        bit         seen;

        tbl[0] = '{mode: 2'd0, seed: 8'h00, d0: 8'h00, dlast: 8'h3F};
        tbl[1] = '{mode: 2'd1, seed: 8'hF0, d0: 8'hF0, dlast: 8'h2F};
        tbl[2] = '{mode: 2'd2, seed: 8'h00, d0: 8'h01, dlast: 8'h80};
        tbl[3] = '{mode: 2'd3, seed: 8'hA5, d0: 8'hA5, dlast: 8'hA5};

        bus.start = 0; bus.abort = 0; bus.cont = 0; bus.mode = 0; bus.seed = 0;
        bus_s.start = 0; bus_s.abort = 0; bus_s.cont = 0; bus_s.mode = 0; bus_s.seed = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_small_en", 32'(bus_s.ram_wr_en), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            run_fill(tbl[v].mode, tbl[v].seed, -1, -1, d0, dl);
            chk("tbl_first", 32'(d0), 32'(tbl[v].d0));
            chk("tbl_last",  32'(dl), 32'(tbl[v].dlast));
        end

        run_fill(2'd0, 8'h00, 5, -1, d0, dl);
        run_fill(2'd1, 8'h10, -1, 20, d0, dl);
        @(negedge clk);

        // Continuous fill: three wraps, then abort at address 10.
        pulse_start(2'd0, 8'h00, 1'b1);
        for (int c = 0; c <= 64 * 3 + 10; c++) begin
            chk("cont_en",   32'(bus.ram_wr_en),   32'd1);
            chk("cont_addr", 32'(bus.ram_wr_addr), 32'(c % 64));
            chk("cont_done", 32'(bus.done),        32'd0);
            chk("cont_pass", 32'(bus.pass_cnt),    32'(c / 64));
            if (c == 64 * 3 + 10) bus.abort = 1'b1;
            @(negedge clk);
        end
        bus.abort = 1'b0;
        bus.cont  = 1'b0;
        chk("abort_en",   32'(bus.ram_wr_en), 32'd0);
        chk("abort_done", 32'(bus.done),      32'd0);
        chk("abort_busy", 32'(bus.busy),      32'd0);
        chk("abort_rd",   32'(bus.rd_flag),   32'd1);
        chk("abort_pass", 32'(bus.pass_cnt),  32'd3);
        @(negedge clk);
        chk("abort_done2", 32'(bus.done), 32'd0);

        // Restart in the done cycle: one idle cycle, then a fresh fill.
        pulse_start(2'd0, 8'h00, 1'b0);
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (bus.done) seen = 1;
            else @(negedge clk);
        end
        chk("b2b_done_seen", 32'(seen), 32'd1);
        chk("b2b_idle_en",   32'(bus.ram_wr_en), 32'd0);
        pulse_start(2'd2, 8'h00, 1'b0);
        chk("b2b_en",   32'(bus.ram_wr_en),   32'd1);
        chk("b2b_addr", 32'(bus.ram_wr_addr), 32'd0);
        chk("b2b_data", 32'(bus.ram_wr_data), 32'h01);
        chk("b2b_rd",   32'(bus.rd_flag),     32'd0);
        chk("b2b_pass", 32'(bus.pass_cnt),    32'd0);
        chk("b2b_busy", 32'(bus.busy),        32'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("b2b_abort_en",   32'(bus.ram_wr_en), 32'd0);
        chk("b2b_abort_done", 32'(bus.done),      32'd0);

        // Four-word instance: rd_flag and done rise together.
        bus_s.start = 1'b1;
        @(negedge clk);
        bus_s.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("small_en",   32'(bus_s.ram_wr_en),   32'd1);
            chk("small_addr", 32'(bus_s.ram_wr_addr), 32'(k));
            chk("small_data", 32'(bus_s.ram_wr_data), 32'(k));
            chk("small_rd",   32'(bus_s.rd_flag),     32'd0);
            chk("small_done", 32'(bus_s.done),        32'd0);
            @(negedge clk);
        end
        chk("small_end_en",   32'(bus_s.ram_wr_en), 32'd0);
        chk("small_end_done", 32'(bus_s.done),      32'd1);
        chk("small_end_rd",   32'(bus_s.rd_flag),   32'd1);
        chk("small_end_pass", 32'(bus_s.pass_cnt),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
